div_sequencer: RTL and testbench

DIV_SEQUENCER -- requirements
Module: div_sequencer

---
 rtl/div_sequencer.sv | 149 ++++++++++++++
 tb/tb_div_sequencer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/div_sequencer.sv
// div_sequencer: Newton-Raphson mantissa divider built around one shared 2MS x 2MS multiplier.
// Build option DIV_SEQ_EXTRA_ITER_EN selects two refinement iterations instead of one.
module div_sequencer #(
  parameter int unsigned MS = 14,
  parameter int unsigned TS = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [TS-1:0]   te1,
  input  logic [TS-1:0]   te2,
  input  logic [MS-1:0]   mant1,
  input  logic [MS-1:0]   mant2,
  input  logic [2*MS-1:0] seed_x0,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3*MS-1:0] mant_out,
  output logic [TS-1:0]   te_out,
  output logic            busy
);

`ifdef DIV_SEQ_EXTRA_ITER_EN
  localparam logic [1:0] NIter = 2'd2;
`else
  localparam logic [1:0] NIter = 2'd1;
`endif

  typedef enum logic [2:0] {StIdle, StMulDx, StMulXt, StMulQ, StDone} state_e;

  state_e          state_q, state_d;
  logic [MS-1:0]   m1_q, m1_d, m2_q, m2_d;
  logic [TS-1:0]   diff_q, diff_d, te_q, te_d;
  logic [2*MS-1:0] x_q, x_d, t_q, t_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [3*MS-1:0] mant_q, mant_d;

  logic [2*MS-1:0] mul_a, mul_b;
  logic [4*MS-1:0] prod;
  logic [2*MS:0]   p_trunc, t_full;
  logic [3*MS-1:0] q;
  logic            unused_bits;

  // Operand select depends only on the current state, keeping the datapath loop-free.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state_q)
      StMulDx: begin
        mul_a = {{MS{1'b0}}, m2_q};
        mul_b = x_q;
      end
      StMulXt: begin
        mul_a = x_q;
        mul_b = t_q;
      end
      StMulQ: begin
        mul_a = {{MS{1'b0}}, m1_q};
        mul_b = x_q;
      end
      default: ;
    endcase
  end

  assign prod        = {{2*MS{1'b0}}, mul_a} * {{2*MS{1'b0}}, mul_b};
  assign p_trunc     = prod[3*MS-1:MS-1];
  assign t_full      = {1'b1, {2*MS{1'b0}}} - p_trunc;
  assign q           = prod[3*MS-1:0];
  assign unused_bits = ^{prod[4*MS-1], t_full[2*MS]};

  always_comb begin
    state_d = state_q;
    m1_d    = m1_q;
    m2_d    = m2_q;
    diff_d  = diff_q;
    x_d     = x_q;
    t_d     = t_q;
    cnt_d   = cnt_q;
    mant_d  = mant_q;
    te_d    = te_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          m1_d    = mant1;
          m2_d    = mant2;
          diff_d  = te1 - te2;
          x_d     = seed_x0;
          cnt_d   = '0;
          state_d = StMulDx;
        end
      end
      StMulDx: begin
        t_d     = t_full[2*MS-1:0];
        state_d = StMulXt;
      end
      StMulXt: begin
        x_d     = prod[4*MS-2:2*MS-1];
        cnt_d   = cnt_q + 2'd1;
        state_d = (cnt_d < NIter) ? StMulDx : StMulQ;
      end
      StMulQ: begin
        // Quotient lies in (0.5, 2); shift up one place when it is below 1.
        if (q[3*MS-2]) begin
          mant_d = q;
          te_d   = diff_q;
        end else begin
          mant_d = {q[3*MS-2:0], 1'b0};
          te_d   = diff_q - TS'(1);
        end
        state_d = StDone;
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      m1_q    <= '0;
      m2_q    <= '0;
      diff_q  <= '0;
      x_q     <= '0;
      t_q     <= '0;
      cnt_q   <= '0;
      mant_q  <= '0;
      te_q    <= '0;
    end else begin
      state_q <= state_d;
      m1_q    <= m1_d;
      m2_q    <= m2_d;
      diff_q  <= diff_d;
      x_q     <= x_d;
      t_q     <= t_d;
      cnt_q   <= cnt_d;
      mant_q  <= mant_d;
      te_q    <= te_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign out_valid = (state_q == StDone);
  assign mant_out  = mant_q;
  assign te_out    = te_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: directed cases plus randomized operands
// compared against a plain-arithmetic Newton-Raphson reference.
module tb_div_sequencer;
  localparam int unsigned MS = 14;
  localparam int unsigned TS = 8;
`ifdef DIV_SEQ_EXTRA_ITER_EN
  localparam int NITER = 2;
`else
  localparam int NITER = 1;
`endif

  logic            clk = 1'b0;
  logic            rst, in_valid, in_ready, out_valid, out_ready, busy;
  logic [TS-1:0]   te1, te2, te_out;
  logic [MS-1:0]   mant1, mant2;
  logic [2*MS-1:0] seed_x0;
  logic [3*MS-1:0] mant_out;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  div_sequencer #(.MS(MS), .TS(TS)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .te1      (te1),
    .te2      (te2),
    .mant1    (mant1),
    .mant2    (mant2),
    .seed_x0  (seed_x0),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .mant_out (mant_out),
    .te_out   (te_out),
    .busy     (busy)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble();
    mant1   = MS'($urandom);
    mant2   = MS'($urandom);
    te1     = TS'($urandom);
    te2     = TS'($urandom);
    seed_x0 = (2*MS)'($urandom);
  endtask

  // Reciprocal refinement x <- x*(2 - d*x), then q = n*x, normalised into [1,2).
  function automatic void ref_div(input longint unsigned n, input longint unsigned d,
                                  input logic [TS-1:0] e1, input logic [TS-1:0] e2,
                                  input longint unsigned seed,
                                  output logic [3*MS-1:0] m, output logic [TS-1:0] e);
    longint unsigned x, p, t, qv;
    logic [63:0] qb;
    x = seed;
    for (int i = 0; i < NITER; i++) begin
      p = (d * x) >> (MS - 1);
      t = (64'd1 << (2*MS)) - p;
      x = ((x * t) >> (2*MS - 1)) & ((64'd1 << (2*MS)) - 1);
    end
    qv = n * x;
    qb = qv;
    e  = e1 - e2;
    if (qb[3*MS-2]) begin
      m = qb[3*MS-1:0];
    end else begin
      m = qb[3*MS-2:0] << 1;
      e = e - TS'(1);
    end
  endfunction

  task automatic run_op(input logic [MS-1:0] a, input logic [MS-1:0] b,
                        input logic [TS-1:0] e1, input logic [TS-1:0] e2,
                        input logic [2*MS-1:0] s, input int hold,
                        output logic [3*MS-1:0] rm, output logic [TS-1:0] rt);
    logic [3*MS-1:0] em;
    logic [TS-1:0]   et;
    int cyc, w;
    w = 0;
    while (!in_ready && w < 20) begin
      tick();
      w++;
    end
    check_eq("ready_before_op", in_ready, 1);
    mant1 = a; mant2 = b; te1 = e1; te2 = e2; seed_x0 = s;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    tick();
    cyc = 1;  // the accept cycle counts as cycle 1
    in_valid = 1'b0;
    scramble();
    check_eq("busy_after_accept", busy, 1);
    while (!out_valid && cyc < 40) begin
      tick();
      cyc++;
    end
    check_eq("latency", cyc, 2*NITER + 2);
    ref_div(a, b, e1, e2, s, em, et);
    check_eq("mant_out", mant_out, em);
    check_eq("te_out", te_out, et);
    rm = mant_out;
    rt = te_out;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      scramble();
      tick();
      check_eq("hold_valid", out_valid, 1);
      check_eq("hold_not_ready", in_ready, 0);
      check_eq("hold_mant", mant_out, em);
      check_eq("hold_te", te_out, et);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check_eq("idle_after_handshake", in_ready, 1);
    check_eq("valid_drop", out_valid, 0);
    check_eq("mant_retained", mant_out, em);
    check_eq("te_retained", te_out, et);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [3*MS-1:0] rm;
    logic [TS-1:0]   rt;
    logic [MS-1:0]   field;
    logic [MS-1:0]   ra, rb;
    longint unsigned sd;
    int seen;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    scramble();
    tick();
    tick();
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_mant", mant_out, 0);
    check_eq("rst_te", te_out, 0);
    rst = 1'b0;
    check_eq("rst_in_ready", in_ready, 1);

    // 1.0 / 1.0
    run_op(14'h2000, 14'h2000, 8'd5, 8'd3, 28'h8000000, 0, rm, rt);
    check_eq("unit_mant", rm, 42'h100_0000_0000);
    check_eq("unit_te", rt, 2);

    // 1.5 / 1.0
    run_op(14'h3000, 14'h2000, 8'd0, 8'd0, 28'h8000000, 0, rm, rt);
    check_eq("one_half_mant", rm, 42'h180_0000_0000);
    check_eq("one_half_te", rt, 0);

    // 1.0 / 1.5 needs the normalising shift; long stall with ignored in_valid
    run_op(14'h2000, 14'h3000, 8'd4, 8'd1, 28'h5555555, 10, rm, rt);
    field = rm[40:27];
    check_eq("two_thirds_window", (field >= 14'h2AA9 && field <= 14'h2AAB), 1);
    check_eq("two_thirds_te", rt, 2);

    // Exponent wraparound, including the normalising -1
    run_op(14'h2000, 14'h3000, 8'h80, 8'h01, 28'h5555555, 0, rm, rt);
    check_eq("wrap_te", rt, 8'h7E);

    // Reset in the middle of an operation
    mant1 = 14'h3000; mant2 = 14'h2000; te1 = 8'd7; te2 = 8'd1; seed_x0 = 28'h8000000;
    in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check_eq("mid_busy", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("mid_rst_valid", out_valid, 0);
    check_eq("mid_rst_mant", mant_out, 0);
    check_eq("mid_rst_te", te_out, 0);
    check_eq("mid_rst_ready", in_ready, 1);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid) seen++;
    end
    check_eq("mid_rst_no_valid", seen, 0);
    run_op(14'h2000, 14'h2000, 8'd5, 8'd3, 28'h8000000, 0, rm, rt);
    check_eq("post_rst_mant", rm, 42'h100_0000_0000);

    // Reset wins over a completing handshake and over a new request
    mant1 = 14'h3000; mant2 = 14'h2000; te1 = 8'd1; te2 = 8'd0; seed_x0 = 28'h8000000;
    in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    while (!out_valid && n_checks < 100000) tick();
    out_ready = 1'b1; in_valid = 1'b1; rst = 1'b1;
    tick();
    tick();
    check_eq("rst_prio_mant", mant_out, 0);
    check_eq("rst_prio_busy", busy, 0);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;

    // Randomized operands with seeds near 1/mant2
    for (int k = 0; k < 20; k++) begin
      ra = {1'b1, 13'($urandom)};
      rb = {1'b1, 13'($urandom)};
      sd = (64'd1 << (3*MS - 2)) / rb;
      sd = sd + $urandom_range(0, 2000) - 1000;
      run_op(ra, rb, TS'($urandom), TS'($urandom), (2*MS)'(sd), $urandom_range(0, 3), rm, rt);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
